// File: rtl/ram_pkg.sv
// Shared types and constants for the dual-port synchronous-read RAM.
package ram_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } init_state_e;

  localparam int unsigned RDW_OLD = 0;
  localparam int unsigned RDW_NEW = 1;

endpackage

// File: rtl/ram_init_ctrl.sv
// Post-reset memory clear sequencer: walks every address once, then hands
// the write port over to the user.
module ram_init_ctrl
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  init_busy,
  output logic [ADDR_WIDTH-1:0] clr_addr,
  output logic                  clr_we
);

  init_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      INIT: begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == '1) state_d = READY;
      end
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    init_busy = (state_q == INIT);
    clr_we    = init_busy;
    clr_addr  = cnt_q;
  end

endmodule

// File: rtl/ram_dp_sync_read.sv
// Simple dual-port RAM with byte-enabled writes, synchronous read, optional
// output register, selectable read-during-write behaviour and self-clear.
module ram_dp_sync_read
  import ram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned OUT_REG    = 0,
  parameter int unsigned RDW_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_valid,
  output logic                    init_busy
);

  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
  localparam int unsigned NBYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  clr_we;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NBYTES-1:0]     mem_be;

  logic                  rd_fire;
  logic [DATA_WIDTH-1:0] rd_word;

  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;

  ram_init_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_init (
    .clk      (clk),
    .reset    (reset),
    .init_busy(init_busy),
    .clr_addr (clr_addr),
    .clr_we   (clr_we)
  );

  always_comb begin
    mem_we    = init_busy ? clr_we   : wr_en;
    mem_addr  = init_busy ? clr_addr : wr_addr;
    mem_wdata = init_busy ? '0       : wr_data;
    mem_be    = init_busy ? '1       : wr_be;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // New-data mode forwards the in-flight write bytes over the stored word.
  always_comb begin
    rd_fire = rd_en && !init_busy;
    rd_word = mem[rd_addr];
    if (RDW_MODE == RDW_NEW && wr_en && !init_busy && wr_addr == rd_addr) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (wr_be[b]) rd_word[8*b +: 8] = wr_data[8*b +: 8];
      end
    end
    s1_valid_d = rd_fire;
    s1_data_d  = rd_fire ? rd_word : s1_data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic                  s2_valid_q, s2_valid_d;
    logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;

    always_comb begin
      s2_valid_d = s1_valid_q;
      s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s2_valid_q <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s2_valid_d;
        s2_data_q  <= s2_data_d;
      end
    end

    assign rd_valid = s2_valid_q;
    assign rd_data  = s2_data_q;
  end else begin : g_no_out_reg
    assign rd_valid = s1_valid_q;
    assign rd_data  = s1_data_q;
  end

endmodule

// File: doc/ram_dp_sync_read.md
RAM_DP_SYNC_READ -- requirements
Module: ram_dp_sync_read

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16; word width in bits; must be a multiple of 8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4; depth = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter OUT_REG, default 0; 0 = 1-cycle read latency, 1 = extra output register, 2-cycle latency.
REQ-004 SHALL have parameter RDW_MODE, default 0; same-address read/write collision: 0 = old data, 1 = new data.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port wr_en  input  1  write request.
REQ-008 SHALL have port wr_addr  input  ADDR_WIDTH  write address.
REQ-009 SHALL have port wr_data  input  DATA_WIDTH  write data.
REQ-010 SHALL have port wr_be  input  DATA_WIDTH/8  byte enables; bit k covers wr_data[8k+7:8k].
REQ-011 SHALL have port rd_en  input  1  read request.
REQ-012 SHALL have port rd_addr  input  ADDR_WIDTH  read address.
REQ-013 SHALL have port rd_data  output  DATA_WIDTH  registered read data.
REQ-014 SHALL have port rd_valid  output  1  one-cycle pulse qualifying rd_data.
REQ-015 SHALL have port init_busy  output  1  high while memory clear runs.

Function
REQ-016 SHALL contain a two-state init FSM: INIT, READY; reset forces INIT with clear counter = 0.
REQ-017 In INIT SHALL write 0 to address = counter each cycle, counter +1; at counter = DEPTH-1 SHALL go to READY next edge; INIT lasts exactly DEPTH cycles.
REQ-018 init_busy SHALL equal (state == INIT).
REQ-019 In INIT, wr_en and rd_en SHALL be ignored; no user write lands, rd_valid stays 0.
REQ-020 In READY, wr_en=1 SHALL update at the edge only bytes with wr_be[k]=1; wr_be=0 writes nothing.
REQ-021 In READY, rd_en=1 at edge N SHALL give rd_data/rd_valid=1 after edge N (OUT_REG=0) or after edge N+1 (OUT_REG=1).
REQ-022 Back-to-back reads SHALL sustain one result per cycle, in order.
REQ-023 rd_valid SHALL be 0 in any cycle without a qualifying read; rd_data SHALL then hold its last value.
REQ-024 Same-cycle read and write to the same address: RDW_MODE=0 SHALL return the pre-write word; RDW_MODE=1 SHALL return the post-write word, merged per wr_be.
REQ-025 Read and write to different addresses in the same cycle SHALL both complete without interaction.
REQ-026 Address arithmetic SHALL be ADDR_WIDTH bits; no wrap or out-of-range case exists.

Reset
REQ-027 Asserting reset SHALL immediately force rd_data = 0, rd_valid = 0, init_busy = 1, including the OUT_REG pipeline stage.
REQ-028 Reset SHALL NOT clear the array directly; clearing SHALL come only from INIT after reset deasserts.
REQ-029 Reset during INIT or READY SHALL abort in-flight reads (no rd_valid) and restart INIT from address 0.

Structure
REQ-030 Package ram_pkg SHALL hold FSM state encodings (INIT, READY) and RDW mode constants (RDW_OLD=0, RDW_NEW=1).
REQ-031 The INIT FSM and clear counter SHALL be in sub-module ram_init_ctrl, which outputs init_busy, clear address and clear write strobe.
REQ-032 The array SHALL be a reg array without reset, written on one port (user or clear, muxed by init_busy), read on one synchronous port.

Verification (DATA_WIDTH=16, ADDR_WIDTH=4)
REQ-033 Reset pulse -> init_busy=1 for exactly 16 cycles after deassert, then 0; then reading addresses 0..15 -> 0x0000 each, rd_valid one cycle after rd_en.
REQ-034 Write 0xA5C3 to addr 3, wr_be=2'b11; next cycle write 0xFFFF to addr 3, wr_be=2'b01; read addr 3 -> 0xA5FF.
REQ-035 RDW_MODE=0 and RDW_MODE=1 builds: addr 5 holds 0x1111; same cycle write 0x2222 to addr 5 and read addr 5 -> 0x1111 and 0x2222 respectively; later read -> 0x2222 in both.
REQ-036 OUT_REG=1: reads of addrs 0,1,2 on three consecutive edges, data 0x0010,0x0011,0x0012 -> rd_valid high on the 2nd, 3rd and 4th following edges with data in order.
REQ-037 Assert reset with a read in flight during READY, after writing 0xBEEF to addr 7 -> rd_valid and rd_data 0 at once; INIT reruns; read addr 7 afterwards -> 0x0000.
REQ-038 During INIT, issue wr_en to addr 2 with 0x5555 -> read addr 2 after READY returns 0x0000; rd_en during INIT -> rd_valid stays 0.
